// File: rtl/mem_port_arbiter.sv
// Unified memory port shared by fetch and data sides.
// Data side wins ties unless fetch has been starved STARVE_LIMIT times.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic        stall_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             d_win;
  logic             i_win;

  assign d_win = d_req_i & (~if_req_i | (starve_cnt < LIMIT));
  assign i_win = ~d_win & if_req_i;

  assign cnt_inc = (starve_cnt == '1) ? starve_cnt
                                      : starve_cnt + 1'b1;

  // Low in the ack cycle so the pipeline advances on that edge.
  assign stall_o = (if_req_i & ~if_ack_o)
                 | (d_req_i  & ~d_ack_o);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_data_o   <= '0;
      d_rdata_o   <= '0;
      if_ack_o    <= 1'b0;
      d_ack_o     <= 1'b0;
    end else begin
      if_ack_o <= 1'b0;
      d_ack_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            d_win: begin
              state       <= BUSY_D;
              mem_en_o    <= 1'b1;
              mem_we_o    <= d_we_i;
              mem_addr_o  <= d_addr_i;
              mem_wdata_o <= d_wdata_i;
              starve_cnt  <= if_req_i ? cnt_inc : '0;
            end
            i_win: begin
              state      <= BUSY_I;
              mem_en_o   <= 1'b1;
              mem_we_o   <= 1'b0;
              mem_addr_o <= if_addr_i;
              starve_cnt <= '0;
            end
            default: state <= IDLE;
          endcase
        end
        BUSY_I: begin
          if (mem_ready_i) begin
            state     <= DONE;
            mem_en_o  <= 1'b0;
            mem_we_o  <= 1'b0;
            if_data_o <= mem_rdata_i;
            if_ack_o  <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ready_i) begin
            state    <= DONE;
            mem_en_o <= 1'b0;
            mem_we_o <= 1'b0;
            d_ack_o  <= 1'b1;
            if (!mem_we_o) begin
              d_rdata_o <= mem_rdata_i;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter.
// Per-cycle input/expect table plus a variable-wait fetch sequence.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;

  int total = 0;
  int bad = 0;
  bit mon_on = 0;

  mem_port_arbiter #(
    .STARVE_LIMIT(3),
    .CNT_W(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .if_req_i(if_req),
    .if_addr_i(if_addr),
    .if_data_o(if_data),
    .if_ack_o(if_ack),
    .d_req_i(d_req),
    .d_we_i(d_we),
    .d_addr_i(d_addr),
    .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata),
    .d_ack_o(d_ack),
    .mem_en_o(mem_en),
    .mem_we_o(mem_we),
    .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .mem_ready_i(mem_ready),
    .stall_o(stall)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic [31:0] mrd;
    logic        mrdy;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        iack;
    logic        dack;
    logic [31:0] idata;
    logic [31:0] drd;
    logic        stall;
  } vec_t;

  vec_t vq[$];

  function automatic void add(
    input logic [31:0] rst_v, ireq, iaddr, dreq, dwe,
    input logic [31:0] daddr, dwd, mrd, mrdy,
    input logic [31:0] en, we, addr, wd, iack, dack,
    input logic [31:0] idata, drd, stl
  );
    vec_t t;
    t.rst   = rst_v[0];
    t.ireq  = ireq[0];
    t.iaddr = iaddr;
    t.dreq  = dreq[0];
    t.dwe   = dwe[0];
    t.daddr = daddr;
    t.dwd   = dwd;
    t.mrd   = mrd;
    t.mrdy  = mrdy[0];
    t.en    = en[0];
    t.we    = we[0];
    t.addr  = addr;
    t.wd    = wd;
    t.iack  = iack[0];
    t.dack  = dack[0];
    t.idata = idata;
    t.drd   = drd;
    t.stall = stl[0];
    vq.push_back(t);
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  // Both acks must never be high together.
  always @(negedge clk) begin
    if (mon_on) begin
      total++;
      if (if_ack && d_ack) begin
        bad++;
        $display("FAIL ack_overlap at %0t: if_ack=1 d_ack=1 want not both", $time);
      end
    end
  end

  task automatic fetch_wait(input int w);
    int cyc;
    int en_cnt;
    bit got;
    @(negedge clk);
    if_req    = 1;
    if_addr   = 32'h700 + w;
    mem_ready = 0;
    cyc = 0;
    en_cnt = 0;
    got = 0;
    while (!got && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      mem_ready = 0;
      if (if_ack) begin
        got = 1;
      end else if (mem_en) begin
        mem_ready = (en_cnt == w);
        mem_rdata = 32'hF00 + w;
        en_cnt++;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL fetch_wait w=%0d: no if_ack within 20 cycles", w);
    end else begin
      chk("wait_latency", w, cyc, 2 + w);
      chk("wait_data", w, if_data, 32'hF00 + w);
      chk("wait_addr", w, mem_addr, 32'h700 + w);
    end
    if_req = 0;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pa, pd, rk;
  vec_t t;

  initial begin
    rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
    d_addr = 0; d_wdata = 0; mem_rdata = 0; mem_ready = 0;
    repeat (2) @(posedge clk);
    mon_on = 1;

    // reset state
    add(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
    // fetch, 0 wait
    add(0,1,'h10,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1);
    add(0,1,'h10,0,0,0,0,'h8C220004,1, 1,0,'h10,0,0,0,0,0,1);
    add(0,1,'h10,0,0,0,0,0,0, 0,0,'h10,0,1,0,'h8C220004,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,'h10,0,0,0,'h8C220004,0,0);
    // write, 3 wait; fields changed mid-access must not leak
    add(0,0,0,1,1,'h20,'hDEADBEEF,0,0, 0,0,'h10,0,0,0,'h8C220004,0,1);
    add(0,0,0,1,1,'h20,'hDEADBEEF,0,0, 1,1,'h20,'hDEADBEEF,0,0,'h8C220004,0,1);
    add(0,0,0,1,0,'h24,0,0,0, 1,1,'h20,'hDEADBEEF,0,0,'h8C220004,0,1);
    add(0,0,0,1,1,'h20,'hDEADBEEF,0,0, 1,1,'h20,'hDEADBEEF,0,0,'h8C220004,0,1);
    add(0,0,0,1,1,'h20,'hDEADBEEF,'h12345678,1, 1,1,'h20,'hDEADBEEF,0,0,'h8C220004,0,1);
    add(0,0,0,1,1,'h20,'hDEADBEEF,0,0, 0,0,'h20,'hDEADBEEF,0,1,'h8C220004,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,'h20,'hDEADBEEF,0,0,'h8C220004,0,0);
    // read, 1 wait
    add(0,0,0,1,0,'h44,'h55,0,0, 0,0,'h20,'hDEADBEEF,0,0,'h8C220004,0,1);
    add(0,0,0,1,0,'h44,'h55,0,0, 1,0,'h44,'h55,0,0,'h8C220004,0,1);
    add(0,0,0,1,0,'h44,'h55,'hCAFEF00D,1, 1,0,'h44,'h55,0,0,'h8C220004,0,1);
    add(0,0,0,1,0,'h44,'h55,0,0, 0,0,'h44,'h55,0,1,'h8C220004,'hCAFEF00D,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,'h44,'h55,0,0,'h8C220004,'hCAFEF00D,0);
    // simultaneous: D first, then I
    add(0,1,'h100,1,0,'h200,0,0,0, 0,0,'h44,'h55,0,0,'h8C220004,'hCAFEF00D,1);
    add(0,1,'h100,1,0,'h200,0,'hAAAA0001,1, 1,0,'h200,0,0,0,'h8C220004,'hCAFEF00D,1);
    add(0,1,'h100,1,0,'h200,0,0,0, 0,0,'h200,0,0,1,'h8C220004,'hAAAA0001,1);
    add(0,1,'h100,0,0,0,0,0,0, 0,0,'h200,0,0,0,'h8C220004,'hAAAA0001,1);
    add(0,1,'h100,0,0,0,0,'hBBBB0002,1, 1,0,'h100,0,0,0,'h8C220004,'hAAAA0001,1);
    add(0,1,'h100,0,0,0,0,0,0, 0,0,'h100,0,1,0,'hBBBB0002,'hAAAA0001,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,'h100,0,0,0,'hBBBB0002,'hAAAA0001,0);
    // starvation: three D grants, then fetch forced through
    pa = 'h100;
    pd = 'hAAAA0001;
    for (int k = 1; k <= 3; k++) begin
      rk = 32'hD0000000 + k;
      add(0,1,'h300,1,0,'h400,0,0,0, 0,0,pa,0,0,0,'hBBBB0002,pd,1);
      add(0,1,'h300,1,0,'h400,0,rk,1, 1,0,'h400,0,0,0,'hBBBB0002,pd,1);
      add(0,1,'h300,1,0,'h400,0,0,0, 0,0,'h400,0,0,1,'hBBBB0002,rk,1);
      pa = 'h400;
      pd = rk;
    end
    add(0,1,'h300,1,0,'h400,0,0,0, 0,0,'h400,0,0,0,'hBBBB0002,pd,1);
    add(0,1,'h300,1,0,'h400,0,'h11110000,1, 1,0,'h300,0,0,0,'hBBBB0002,pd,1);
    add(0,1,'h300,1,0,'h400,0,0,0, 0,0,'h300,0,1,0,'h11110000,pd,1);
    // counter cleared: D wins again over a waiting fetch
    add(0,1,'h300,1,0,'h400,0,0,0, 0,0,'h300,0,0,0,'h11110000,pd,1);
    add(0,1,'h300,1,0,'h400,0,'hE0000001,1, 1,0,'h400,0,0,0,'h11110000,pd,1);
    add(0,0,0,1,0,'h400,0,0,0, 0,0,'h400,0,0,1,'h11110000,'hE0000001,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,'h400,0,0,0,'h11110000,'hE0000001,0);
    // reset mid-access, then a clean retry
    add(0,0,0,1,1,'h500,'h77,0,0, 0,0,'h400,0,0,0,'h11110000,'hE0000001,1);
    add(0,0,0,1,1,'h500,'h77,0,0, 1,1,'h500,'h77,0,0,'h11110000,'hE0000001,1);
    add(1,0,0,1,1,'h500,'h77,0,0, 1,1,'h500,'h77,0,0,'h11110000,'hE0000001,1);
    add(0,0,0,1,1,'h500,'h77,0,0, 0,0,0,0,0,0,0,0,1);
    add(0,0,0,1,1,'h500,'h77,'h9999,1, 1,1,'h500,'h77,0,0,0,0,1);
    add(0,0,0,1,1,'h500,'h77,0,0, 0,0,'h500,'h77,0,1,0,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,'h500,'h77,0,0,0,0,0);
    // back-to-back fetches, req held across ack
    add(0,1,'h600,0,0,0,0,0,0, 0,0,'h500,'h77,0,0,0,0,1);
    add(0,1,'h600,0,0,0,0,'h1,1, 1,0,'h600,'h77,0,0,0,0,1);
    add(0,1,'h600,0,0,0,0,0,0, 0,0,'h600,'h77,1,0,'h1,0,0);
    add(0,1,'h600,0,0,0,0,0,0, 0,0,'h600,'h77,0,0,'h1,0,1);
    add(0,1,'h600,0,0,0,0,'h2,1, 1,0,'h600,'h77,0,0,'h1,0,1);
    add(0,1,'h600,0,0,0,0,0,0, 0,0,'h600,'h77,1,0,'h2,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,'h600,'h77,0,0,'h2,0,0);

    for (int i = 0; i < vq.size(); i++) begin
      t = vq[i];
      @(negedge clk);
      rst       = t.rst;
      if_req    = t.ireq;
      if_addr   = t.iaddr;
      d_req     = t.dreq;
      d_we      = t.dwe;
      d_addr    = t.daddr;
      d_wdata   = t.dwd;
      mem_rdata = t.mrd;
      mem_ready = t.mrdy;
      #1;
      chk("mem_en", i, {31'd0, mem_en}, {31'd0, t.en});
      chk("mem_we", i, {31'd0, mem_we}, {31'd0, t.we});
      chk("mem_addr", i, mem_addr, t.addr);
      chk("mem_wdata", i, mem_wdata, t.wd);
      chk("if_ack", i, {31'd0, if_ack}, {31'd0, t.iack});
      chk("d_ack", i, {31'd0, d_ack}, {31'd0, t.dack});
      chk("if_data", i, if_data, t.idata);
      chk("d_rdata", i, d_rdata, t.drd);
      chk("stall", i, {31'd0, stall}, {31'd0, t.stall});
    end

    for (int w = 0; w < 5; w++) begin
      fetch_wait(w);
    end

    mon_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified, variable-latency memory port between the instruction-fetch side (read-only) and the data-memory side (read/write) of the 5-stage pipeline.
- Sequences each access with an FSM and returns read data to the winning requester with a one-cycle ack.
- Drives a pipeline stall while any request is outstanding.
- Data side has priority; a starvation counter guarantees fetch progress.

Parameters:
- STARVE_LIMIT, 3: max consecutive D grants while fetch waits before fetch is forced to win.
- CNT_W, 2: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request; held with address stable until if_ack_o
- if_addr_i  in  32  fetch byte address
- if_data_o  out  32  fetched instruction; valid in the if_ack_o cycle
- if_ack_o  out  1  one-cycle completion pulse, fetch side
- d_req_i  in  1  data request; held with fields stable until d_ack_o
- d_we_i  in  1  1 = write, 0 = read
- d_addr_i  in  32  data byte address
- d_wdata_i  in  32  write data
- d_rdata_o  out  32  read data; valid in the d_ack_o cycle
- d_ack_o  out  1  one-cycle completion pulse, data side
- mem_en_o  out  1  memory access strobe; held until mem_ready_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data; valid when mem_ready_i is high
- mem_ready_i  in  1  memory completion; sampled only while mem_en_o is high
- stall_o  out  1  pipeline freeze request

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, DONE. All outputs are registered except stall_o.
- Reset (sync, any state): state=IDLE; mem_en_o, mem_we_o, if_ack_o, d_ack_o = 0; mem_addr_o, mem_wdata_o, if_data_o, d_rdata_o = 0; starve_cnt = 0. An in-flight access is abandoned and no ack is issued. mem_en_o is low from the first edge with rst_i high.
- IDLE:
  - If d_req_i=1 and (if_req_i=0 or starve_cnt<STARVE_LIMIT): go to BUSY_D. Latch d_we_i, d_addr_i and d_wdata_i into mem_we_o, mem_addr_o and mem_wdata_o. Set mem_en_o=1.
  - Else if if_req_i=1: go to BUSY_I. mem_addr_o=if_addr_i, mem_we_o=0, mem_en_o=1.
  - Else remain in IDLE.
- Starvation counter, updated on each grant:
  - D grant with if_req_i=1: starve_cnt+1, saturating.
  - D grant with if_req_i=0: starve_cnt=0.
  - I grant: starve_cnt=0.
- BUSY_x: mem_en_o and all latched fields are held constant. On mem_ready_i=1:
  - mem_en_o=0 and mem_we_o=0 at the next edge.
  - For BUSY_I, if_data_o<=mem_rdata_i and if_ack_o<=1.
  - For BUSY_D: on a read, d_rdata_o<=mem_rdata_i; on a write, d_rdata_o is unchanged. d_ack_o<=1.
  - Go to DONE.
- DONE: the ack is high for exactly this cycle, then clears. Go to IDLE unconditionally.
- Requester handshake: the requester must drop req in the cycle after ack. A req still high in IDLE is treated as a new request.
- Minimum latency: req seen in IDLE at cycle 0, mem_en_o high at cycle 1, ack at cycle 2 if mem_ready_i=1 at cycle 1. Each extra wait cycle of the memory adds one cycle.
- Ownership: exactly one access in flight. No request is granted outside IDLE. Both acks are never high in the same cycle.
- Request changes: requester input changes while BUSY have no effect on mem_* outputs. Deasserting req while BUSY is illegal and need not be handled.
- stall_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o), combinational. It is low in the ack cycle, so the pipeline advances on that edge.
- Addresses pass through unmodified. Alignment is the requester's responsibility.

Test Plan:
- Fetch only: if_addr_i=0x00000010, memory returns 0x8C220004 with 0 wait cycles -> mem_en_o high at cycle 1, if_ack_o=1 and if_data_o=0x8C220004 at cycle 2, stall_o high at cycles 0–1.
- Data write with 3 wait cycles: d_we_i=1, d_addr_i=0x20, d_wdata_i=0xDEADBEEF -> mem_we_o=1 for 4 cycles, d_ack_o at cycle 5, d_rdata_o unchanged.
- Simultaneous requests, starve_cnt=0: both high at cycle 0 -> D is served first. if_ack_o follows on the next arbitration; no overlap of mem_en_o between the two accesses.
- Starvation: if_req_i held high, d_req_i re-requesting continuously, STARVE_LIMIT=3 -> exactly 3 D acks, then an I grant, and starve_cnt=0 afterwards.
- Reset mid-access: rst_i high for 1 cycle during BUSY_D with mem_ready_i=0 -> mem_en_o=0 after that edge, no d_ack_o, state IDLE. A subsequent request completes normally.
- Back-to-back fetches with req held across ack -> the second access starts in the IDLE cycle after DONE, giving a 3-cycle spacing between consecutive if_ack_o pulses at 0 wait.
